// File: rtl/pipe_adder_arbiter_if.sv
// Client-side bus of pipe_adder_arbiter: packed operand requests in, one-hot tagged sums out.
// master = requester cluster, slave = arbiter.
interface pipe_adder_arbiter_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/pipe_adder_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined adder among N requesters, with a tag pipeline
// that steers each sum back to its issuer. Define PIPE_ARB_STATS_EN to add per-requester grant counters.
module pipe_adder_arbiter #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int LAT = 5,
    parameter int IW  = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    pipe_adder_arbiter_if.slave bus,
    output logic [W-1:0]        o_add_a,
    output logic [W-1:0]        o_add_b,
    input  logic [W-1:0]        i_add_s,
    input  logic                i_add_cout
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [N*16-1:0]     o_grant_cnt
`endif
);

    logic [IW-1:0]        r_rr_ptr;
    logic [2*N-1:0]       w_valid2;
    logic [IW:0]          w_pos;
    logic                 w_any;
    logic [IW-1:0]        w_gidx;
    logic [N-1:0]         w_grant;
    logic [W-1:0]         w_req_a [N];
    logic [W-1:0]         w_req_b [N];
    logic [W-1:0]         r_add_a;
    logic [W-1:0]         r_add_b;
    logic [LAT:0]         r_tag_v;
    logic [LAT:0][IW-1:0] r_tag_idx;
    logic [N-1:0]         r_rsp_valid;
    logic [W-1:0]         r_rsp_sum;
    logic                 r_rsp_cout;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_req_a[g] = bus.req_a[g*W +: W];
        assign w_req_b[g] = bus.req_b[g*W +: W];
    end

    assign w_valid2 = {bus.req_valid, bus.req_valid};

    // Scanning a doubled request vector from rr_ptr handles the wrap without a modulo.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_pos  = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (!w_any && w_valid2[w_pos]) begin
                w_any  = 1'b1;
                w_gidx = (w_pos >= (IW+1)'(N)) ? IW'(w_pos - (IW+1)'(N)) : IW'(w_pos);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_any) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign bus.req_ready = w_grant;

    // Issue register doubles as the adder input stage; tag[0] is loaded on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_tag_v   <= '0;
            r_tag_idx <= '0;
        end else begin
            if (w_any) begin
                r_rr_ptr <= (w_gidx == IW'(N-1)) ? '0 : w_gidx + 1'b1;
                r_add_a  <= w_req_a[w_gidx];
                r_add_b  <= w_req_b[w_gidx];
            end else begin
                r_add_a  <= '0;
                r_add_b  <= '0;
            end
            r_tag_v   <= {r_tag_v[LAT-1:0], w_any};
            r_tag_idx <= {r_tag_idx[LAT-1:0], w_gidx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else if (r_tag_v[LAT]) begin
            r_rsp_valid <= N'(1) << r_tag_idx[LAT];
            r_rsp_sum   <= i_add_s;
            r_rsp_cout  <= i_add_cout;
        end else begin
            r_rsp_valid <= '0;
        end
    end

    assign o_add_a       = r_add_a;
    assign o_add_b       = r_add_b;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;

`ifdef PIPE_ARB_STATS_EN
    logic [N-1:0][15:0] r_grant_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_grant[k] && (r_grant_cnt[k] != 16'hFFFF)) begin
                    r_grant_cnt[k] <= r_grant_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule
